// File: rtl/hog_svm_pkg.sv
// ---- hog_svm_pkg: shared derivations, FSM encodings and saturating add | Rev 1.0 ----
`default_nettype none

package hog_svm_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   function automatic int features_per_block(input int input_width, input int feature_width);
      return input_width / feature_width;
   endfunction

   // Unsigned feature times signed weight needs one extra sign bit; the 9-way sum adds clog2 bits.
   function automatic int block_sum_width(input int feature_width, input int weight_width,
                                          input int n_features);
      return feature_width + weight_width + 1 + $clog2(n_features);
   endfunction

   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int width);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sum = a + b;
      hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      if (sum > hi)
         return hi;
      else if (sum < lo)
         return lo;
      return sum;
   endfunction

endpackage

`default_nettype wire

// File: rtl/svm_block_mac.sv
// ---- svm_block_mac: combinational 9-way unsigned-feature x signed-weight dot product | Rev 1.0 ----
`default_nettype none

module svm_block_mac #(
   parameter int FEATURE_WIDTH      = 4,
   parameter int WEIGHT_WIDTH       = 8,
   parameter int FEATURES_PER_BLOCK = 9,
   parameter int SUM_WIDTH          = 17
) (
   input  logic [FEATURE_WIDTH*FEATURES_PER_BLOCK-1:0] block,
   input  logic [WEIGHT_WIDTH*FEATURES_PER_BLOCK-1:0]  weights,
   output logic signed [SUM_WIDTH-1:0]                 block_sum
);

   localparam int PROD_WIDTH = FEATURE_WIDTH + WEIGHT_WIDTH + 1;

   logic signed [PROD_WIDTH-1:0] prod [FEATURES_PER_BLOCK];

   for (genvar f = 0; f < FEATURES_PER_BLOCK; f++) begin : g_feat
      // Zero-extend the feature so it multiplies as a non-negative signed value.
      assign prod[f] = PROD_WIDTH'($signed({1'b0, block[f*FEATURE_WIDTH +: FEATURE_WIDTH]}))
                     * PROD_WIDTH'($signed(weights[f*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
   end

   always_comb begin
      block_sum = '0;
      for (int f = 0; f < FEATURES_PER_BLOCK; f++)
         block_sum = block_sum + SUM_WIDTH'(prod[f]);
   end

endmodule

`default_nettype wire

// File: rtl/svm_window_classifier.sv
// ---- svm_window_classifier: linear SVM over a 32-block window, one block/cycle | Rev 1.0 ----
// ---- Optional macro SVM_ACC_SAT_EN: saturating accumulate and bias add instead of wrap ----
`default_nettype none

module svm_window_classifier
   import hog_svm_pkg::*;
#(
   parameter int INPUT_WIDTH       = 36,
   parameter int BLOCKS_PER_WINDOW = 32,
   parameter int FEATURE_WIDTH     = 4,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int ACC_WIDTH         = 24,
   parameter int WINDOW_WIDTH      = INPUT_WIDTH * BLOCKS_PER_WINDOW
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WINDOW_WIDTH-1:0]       detection_window,
   output logic                          weight_rd_en,
   output logic [$clog2(BLOCKS_PER_WINDOW)-1:0] weight_addr,
   input  logic [features_per_block(INPUT_WIDTH, FEATURE_WIDTH)*WEIGHT_WIDTH-1:0] weight_data,
   input  logic [ACC_WIDTH-1:0]          bias,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ACC_WIDTH-1:0]          score,
   output logic                          detect
);

   localparam int FEATURES_PER_BLOCK = features_per_block(INPUT_WIDTH, FEATURE_WIDTH);
   localparam int SUM_WIDTH          = block_sum_width(FEATURE_WIDTH, WEIGHT_WIDTH, FEATURES_PER_BLOCK);
   localparam int ADDR_WIDTH         = $clog2(BLOCKS_PER_WINDOW);

   logic [1:0]                  state;
   logic [WINDOW_WIDTH-1:0]     win;
   logic [ADDR_WIDTH-1:0]       blk_cnt;
   logic [ADDR_WIDTH-1:0]       rd_blk;
   logic                        rd_q;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] score_next;
   logic signed [SUM_WIDTH-1:0] blk_sum;
   logic [ACC_WIDTH-1:0]        score_r;
   logic                        detect_r;

   assign in_ready     = (state == ST_IDLE) && !rst;
   assign weight_rd_en = (state == ST_RUN);
   assign weight_addr  = blk_cnt;
   assign out_valid    = (state == ST_RESULT);
   assign score        = score_r;
   assign detect       = detect_r;

   // ROM data arrives one cycle after the read, so the mux follows the delayed block index.
   svm_block_mac #(
      .FEATURE_WIDTH      (FEATURE_WIDTH),
      .WEIGHT_WIDTH       (WEIGHT_WIDTH),
      .FEATURES_PER_BLOCK (FEATURES_PER_BLOCK),
      .SUM_WIDTH          (SUM_WIDTH)
   ) u_mac (
      .block     (win[rd_blk*INPUT_WIDTH +: INPUT_WIDTH]),
      .weights   (weight_data),
      .block_sum (blk_sum)
   );

`ifdef SVM_ACC_SAT_EN
   logic signed [63:0] acc_wide;
   logic signed [63:0] score_wide;

   always_comb begin
      acc_wide   = sat_add(64'(acc), 64'(blk_sum), ACC_WIDTH);
      acc_next   = acc_wide[ACC_WIDTH-1:0];
      score_wide = sat_add(64'(acc_next), 64'($signed(bias)), ACC_WIDTH);
      score_next = score_wide[ACC_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_next   = acc + ACC_WIDTH'(blk_sum);
      score_next = acc_next + $signed(bias);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         win      <= '0;
         blk_cnt  <= '0;
         rd_blk   <= '0;
         rd_q     <= 1'b0;
         acc      <= '0;
         score_r  <= '0;
         detect_r <= 1'b0;
      end else begin
         rd_q   <= weight_rd_en;
         rd_blk <= blk_cnt;
         if (rd_q)
            acc <= acc_next;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  win     <= detection_window;
                  acc     <= '0;
                  blk_cnt <= '0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               blk_cnt <= blk_cnt + ADDR_WIDTH'(1);
               if (blk_cnt == ADDR_WIDTH'(BLOCKS_PER_WINDOW - 1))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               score_r  <= score_next;
               detect_r <= ~score_next[ACC_WIDTH-1] & (|score_next);
               state    <= ST_RESULT;
            end
            ST_RESULT: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_svm_window_classifier.sv
// ---- tb_svm_window_classifier: directed vector table plus handshake, abort and narrow-accumulator sequences | Rev 1.0 ----
`default_nettype none

module tb_svm_window_classifier;

   localparam int WW = 1152;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, weight_rd_en, out_valid, out_ready, detect;
   logic [WW-1:0] detection_window;
   logic [4:0]    weight_addr;
   logic [71:0]   weight_data, rom_word;
   logic [23:0]   bias, score;

   logic          v16, r16, rd16, ov16, det16;
   logic [4:0]    a16;
   logic [71:0]   wd16;
   logic [15:0]   score16;
   logic [WW-1:0] win16;
   logic [15:0]   bias16;
   logic          ordy16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   svm_window_classifier dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .detection_window(detection_window), .weight_rd_en(weight_rd_en),
      .weight_addr(weight_addr), .weight_data(weight_data), .bias(bias),
      .out_valid(out_valid), .out_ready(out_ready), .score(score), .detect(detect)
   );

   svm_window_classifier #(.ACC_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
      .detection_window(win16), .weight_rd_en(rd16),
      .weight_addr(a16), .weight_data(wd16), .bias(bias16),
      .out_valid(ov16), .out_ready(ordy16), .score(score16), .detect(det16)
   );

   always @(posedge clk) if (weight_rd_en) weight_data <= rom_word;
   always @(posedge clk) if (rd16) wd16 <= {9{8'h80}};

   typedef struct {
      logic [3:0]         feat;
      bit                 ramp;
      logic [7:0]         wt;
      logic signed [23:0] b;
      logic signed [23:0] exp_score;
      logic               exp_det;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic load(input logic [3:0] f, input bit ramp, input logic [7:0] w, input logic [23:0] b);
      for (int i = 0; i < 288; i++)
         detection_window[i*4 +: 4] = ramp ? 4'(i % 9) : f;
      rom_word = {9{w}};
      bias     = b;
   endtask

   task automatic accept();
      int n = 0;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Entered one cycle after the accept edge; k is the cycle index relative to that edge.
   task automatic wait_result(output int k, output int rdn, output bit addr_ok);
      k = 1; rdn = 0; addr_ok = 1'b1;
      while (!out_valid && k < 200) begin
         if (weight_rd_en) begin
            if (weight_addr != rdn[4:0]) addr_ok = 1'b0;
            rdn++;
         end
         @(posedge clk); #1; k++;
      end
      chk("result_timeout", out_valid, 1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int  k, rdn, n, amax;
      bit  aok, stable;

      vecs[0] = '{4'd1,  1'b0, 8'h01, 24'sd0,        24'sd288,     1'b1};
      vecs[1] = '{4'd1,  1'b0, 8'h01, -24'sd288,     24'sd0,       1'b0};
      vecs[2] = '{4'd15, 1'b0, 8'h80, 24'sd0,        -24'sd552960, 1'b0};
      vecs[3] = '{4'd1,  1'b0, 8'h01, -24'sd289,     -24'sd1,      1'b0};
      vecs[4] = '{4'd0,  1'b1, 8'h03, -24'sd3455,    24'sd1,       1'b1};
      vecs[5] = '{4'd2,  1'b0, 8'hFF, 24'sd576,      24'sd0,       1'b0};
`ifdef SVM_ACC_SAT_EN
      vecs[6] = '{4'd15, 1'b0, 8'h7F, 24'sd8388607,  24'sd8388607, 1'b1};
`else
      vecs[6] = '{4'd15, 1'b0, 8'h7F, 24'sd8388607,  -24'sd7839969, 1'b0};
`endif

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; detection_window = '0;
      rom_word = '0; bias = '0;
      v16 = 1'b0; win16 = {288{4'hF}}; bias16 = '0; ordy16 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_score", score, 0);
      chk("reset_detect", detect, 0);
      chk("reset_rd_en", weight_rd_en, 0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < NV; i++) begin
         load(vecs[i].feat, vecs[i].ramp, vecs[i].wt, vecs[i].b);
         accept();
         wait_result(k, rdn, aok);
         chk($sformatf("v%0d_latency", i), k, 34);
         chk($sformatf("v%0d_rd_count", i), rdn, 32);
         chk($sformatf("v%0d_addr_seq", i), aok, 1);
         chk($sformatf("v%0d_score", i), $signed(score), vecs[i].exp_score);
         chk($sformatf("v%0d_detect", i), detect, vecs[i].exp_det);
         chk($sformatf("v%0d_busy_in_ready", i), in_ready, 0);
         release_result();
      end

      // Backpressure: result held while a second window waits.
      load(4'd1, 1'b0, 8'h01, 24'sd0);
      accept();
      wait_result(k, rdn, aok);
      load(4'd2, 1'b0, 8'h01, 24'sd0);
      in_valid = 1'b1;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if ($signed(score) != 24'sd288 || detect != 1'b1 || out_valid != 1'b1 || in_ready != 1'b0)
            stable = 1'b0;
         @(posedge clk); #1;
      end
      chk("hold_stable", stable, 1);
      chk("handshake_cycle_in_ready", in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_handshake_out_valid", out_valid, 0);
      chk("post_handshake_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("second_accepted", in_ready, 0);
      wait_result(k, rdn, aok);
      chk("second_latency", k, 34);
      chk("second_score", $signed(score), 576);
      release_result();

      // Abort mid-window, then a fresh window must be unaffected.
      load(4'd15, 1'b0, 8'h80, 24'sd0);
      accept();
      repeat (15) begin @(posedge clk); #1; end
      chk("abort_point_addr", weight_addr, 15);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_rd_en", weight_rd_en, 0);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      chk("abort_no_stale", out_valid, 0);
      load(4'd1, 1'b0, 8'h01, 24'sd0);
      accept();
      wait_result(k, rdn, aok);
      chk("after_abort_score", $signed(score), 288);
      chk("after_abort_detect", detect, 1);
      release_result();

      // Narrow accumulator: wrap or saturate depending on build.
      v16 = 1'b1;
      n = 0;
      while (!r16 && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      v16 = 1'b0;
      n = 0; amax = 0;
      while (!ov16 && n < 100) begin
         if (rd16 && int'(a16) > amax) amax = int'(a16);
         @(posedge clk); #1; n++;
      end
      chk("w16_valid", ov16, 1);
      chk("w16_last_addr", amax, 31);
`ifdef SVM_ACC_SAT_EN
      chk("w16_score", $signed(score16), -32768);
`else
      chk("w16_score", $signed(score16), -28672);
`endif
      chk("w16_detect", det16, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
